// File: rtl/envelope_vca_pkg.sv
// rtl/envelope_vca_pkg.sv - shared types, constants and saturation helper for the envelope VCA
package envelope_vca_pkg;

   localparam int VCA_DW = 16;
   localparam int VCA_GW = VCA_DW + 1;

   typedef logic [VCA_GW-1:0] gain_t;

   localparam gain_t ENV_UNITY = gain_t'(1 << (VCA_DW - 1));

   function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int dw);
      logic signed [63:0] v_hi;
      logic signed [63:0] v_lo;
      v_hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      v_lo = -(64'sd1 <<< (dw - 1));
      if (x > v_hi) begin
         return v_hi;
      end else if (x < v_lo) begin
         return v_lo;
      end else begin
         return x;
      end
   endfunction

endpackage

// File: rtl/envelope_vca_gain_slew_limiter.sv
// rtl/envelope_vca_gain_slew_limiter.sv - gain register with envelope clamp and per-beat slew limit
module gain_slew_limiter
   import envelope_vca_pkg::*;
#(
   parameter int DATA_WIDTH = VCA_DW,
   parameter int MAX_STEP   = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] i_envelope,
   input  logic                  i_accept,
   output logic [DATA_WIDTH:0]   o_gain_next,
   output logic [DATA_WIDTH:0]   o_gain
);

   localparam int GW = DATA_WIDTH + 1;
   localparam int CW = DATA_WIDTH + 2;
   localparam logic [GW-1:0] UNITY = GW'(1) << (DATA_WIDTH - 1);
   localparam logic [CW-1:0] STEP  = CW'(MAX_STEP);

   logic [GW-1:0] r_gain;
   logic [GW-1:0] w_env;
   logic [GW-1:0] w_target;
   logic [CW-1:0] w_gain_ext;
   logic [CW-1:0] w_target_ext;
   logic [CW-1:0] w_up;
   logic [CW-1:0] w_target_plus;

   // Sign-set envelope codes and the ADSR peak wrap all collapse onto unity.
   assign w_env    = {1'b0, i_envelope};
   assign w_target = (w_env > UNITY) ? UNITY : w_env;

   // One extra bit keeps both comparisons free of wrap; the down test adds
   // the step to the target instead of subtracting it from the gain.
   assign w_gain_ext    = {1'b0, r_gain};
   assign w_target_ext  = {1'b0, w_target};
   assign w_up          = w_gain_ext + STEP;
   assign w_target_plus = w_target_ext + STEP;

   always_comb begin
      o_gain_next = w_target;
      if (MAX_STEP != 0) begin
         if (w_target_ext > w_up) begin
            o_gain_next = w_up[GW-1:0];
         end else if (w_target_plus < w_gain_ext) begin
            o_gain_next = r_gain - STEP[GW-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_gain <= '0;
      end else if (i_accept) begin
         r_gain <= o_gain_next;
      end
   end

   assign o_gain = r_gain;

endmodule

// File: rtl/envelope_vca.sv
// rtl/envelope_vca.sv - two-stage envelope-controlled amplifier with valid/ready flow control
module envelope_vca
   import envelope_vca_pkg::*;
#(
   parameter int DATA_WIDTH = VCA_DW,
   parameter int MAX_STEP   = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] sample_i,
   input  logic                  sample_valid_i,
   output logic                  sample_ready_o,
   input  logic [DATA_WIDTH-1:0] envelope_i,
   output logic [DATA_WIDTH-1:0] sample_o,
   output logic                  sample_valid_o,
   input  logic                  sample_ready_i,
   output logic [DATA_WIDTH:0]   gain_o
);

   localparam int PW = 2 * DATA_WIDTH + 1;
   localparam logic signed [PW-1:0] ROUND = PW'(1) << (DATA_WIDTH - 2);

   logic                  w_adv;
   logic                  w_accept;
   logic [DATA_WIDTH:0]   w_gain_next;
   logic signed [PW-1:0]  w_samp_ext;
   logic signed [PW-1:0]  w_gain_ext;
   logic signed [PW-1:0]  w_prod;
   logic signed [PW-1:0]  w_round;
   logic signed [PW-1:0]  w_shift;
   logic signed [63:0]    w_wide;

   logic                  r_s1_valid;
   logic signed [PW-1:0]  r_s1_prod;
   logic                  r_valid_o;
   logic [DATA_WIDTH-1:0] r_sample_o;

   // Single global stall: the whole pipe moves only when the output slot frees.
   assign w_adv          = !r_valid_o || sample_ready_i;
   assign w_accept       = w_adv && sample_valid_i;
   assign sample_ready_o = w_adv;

   gain_slew_limiter #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_STEP   (MAX_STEP)
   ) u_gain (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_envelope  (envelope_i),
      .i_accept    (w_accept),
      .o_gain_next (w_gain_next),
      .o_gain      (gain_o)
   );

   assign w_samp_ext = {{(DATA_WIDTH + 1){sample_i[DATA_WIDTH-1]}}, sample_i};
   assign w_gain_ext = {{DATA_WIDTH{1'b0}}, w_gain_next};
   assign w_prod     = w_samp_ext * w_gain_ext;

   // Round half up, then drop the unity scale with an arithmetic shift.
   assign w_round = r_s1_prod + ROUND;
   assign w_shift = w_round >>> (DATA_WIDTH - 1);
   assign w_wide  = {{(64 - PW){w_shift[PW-1]}}, w_shift};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_s1_valid <= 1'b0;
         r_s1_prod  <= '0;
         r_valid_o  <= 1'b0;
         r_sample_o <= '0;
      end else if (w_adv) begin
         r_s1_valid <= w_accept;
         r_s1_prod  <= w_prod;
         r_valid_o  <= r_s1_valid;
         r_sample_o <= DATA_WIDTH'(saturate(w_wide, DATA_WIDTH));
      end
   end

   assign sample_valid_o = r_valid_o;
   assign sample_o       = r_sample_o;

endmodule

// File: doc/envelope_vca.md
Name: envelope_vca

Overview:
- Voltage-controlled-amplifier stage that sits directly downstream of the ADSR envelope generator.
- Multiplies an oscillator sample stream by the envelope level to produce the shaped voice output.
- Valid/ready handshakes on input and output; fixed 2-cycle pipeline.
- An optional per-sample slew limiter on the gain removes zipper noise from coarse envelope steps.

Parameters:
- DATA_WIDTH, 16: sample and envelope width, signed two's complement.
- MAX_STEP, 0: maximum gain change per accepted sample, in gain LSBs. 0 disables slewing, so gain follows the envelope directly.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- sample_i  in  DATA_WIDTH  signed input sample.
- sample_valid_i  in  1  input beat valid.
- sample_ready_o  out  1  input beat accepted when high together with sample_valid_i.
- envelope_i  in  DATA_WIDTH  envelope level from the ADSR stage. Sampled once per accepted beat.
- sample_o  out  DATA_WIDTH  signed shaped sample.
- sample_valid_o  out  1  output beat valid.
- sample_ready_i  in  1  downstream ready.
- gain_o  out  DATA_WIDTH+1  current applied gain, unsigned (debug/metering).

Behaviour:
- Reset values (async assert, sync release to the first clk_i edge): sample_valid_o=0, sample_o=0, gain_o=0, stage-1 valid=0.
- Envelope interpretation: envelope_i is treated as unsigned.
  - 0x8000 means unity gain (2^(DATA_WIDTH-1)).
  - Any value above 0x8000 clamps to 0x8000.
  - This absorbs the ADSR peak wrap to 0x8000 and any sign-set values.
- Gain is an unsigned (DATA_WIDTH+1)-bit register gain_q, range 0..2^(DATA_WIDTH-1).
- Slew, evaluated combinationally on each accepted beat (target = clamped envelope):
  - MAX_STEP=0: g_next = target.
  - target > gain_q+MAX_STEP: g_next = gain_q+MAX_STEP.
  - target < gain_q-MAX_STEP: g_next = gain_q-MAX_STEP. No underflow: compare before subtracting.
  - Otherwise: g_next = target.
  - gain_q <= g_next at the accepting edge. gain_q holds when no beat is accepted.
- Pipeline: two stages with a global stall.
  - adv = !sample_valid_o || sample_ready_i.
  - sample_ready_o = adv. This is combinational from registered state and sample_ready_i only. It does not depend on sample_valid_i.
- Stage 1 (on adv):
  - s1_valid <= accepted.
  - s1_prod <= sample_i * g_next, signed 2*DATA_WIDTH+1 bits; gain zero-extended to signed.
- Stage 2 (on adv):
  - sample_valid_o <= s1_valid.
  - sample_o <= sat((s1_prod + 2^(DATA_WIDTH-2)) >>> (DATA_WIDTH-1)).
  - Round half up, arithmetic shift.
  - sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Latency: accepted beat appears on sample_o exactly 2 cycles later when not stalled. Throughput is 1 beat/cycle.
- Stall: while sample_valid_o=1 and sample_ready_i=0, all pipeline registers, gain_q and sample_ready_o=0 hold. Output data stays stable while valid and not ready.
- Bubbles: when sample_valid_i=0, a bubble (s1_valid=0) enters the pipe. Bubbles do not update gain_q.
- Simultaneous: an output beat and a new input beat can be accepted in the same cycle.
- Reset mid-stream: in-flight beats are discarded and gain restarts at 0. No output beat is emitted for them.

Decomposition:
- Shared synth package holds:
  - ENV_UNITY constant (2^(DATA_WIDTH-1)).
  - A saturate function.
  - A gain_t typedef (unsigned DATA_WIDTH+1).
- One natural sub-module: gain_slew_limiter (gain_q register plus clamp/slew logic, with an accept strobe).
- Multiply/round/saturate stays in envelope_vca.

Test Plan:
- Unity gain, MAX_STEP=0: envelope_i=0x8000, sample_i=-32768, then 32767 -> sample_o=-32768, then 32767, valid 2 cycles after each accept.
- Half gain with rounding: envelope_i=0x4000, sample_i=16384 -> 8192; sample_i=1 -> 1; sample_i=-1 -> 0.
- Clamp: envelope_i=0xFFFF, sample_i=1000 -> gain_o=0x8000, sample_o=1000.
- Slew: MAX_STEP=256, gain at 0, envelope_i=0x8000, 4 consecutive beats -> gain_o=256, 512, 768, 1024. Envelope then drops to 0 -> gain decrements by 256 per beat, flooring at 0. Gain holds across idle cycles.
- Backpressure: stream 8 beats with sample_ready_i low for 5 cycles mid-stream -> sample_ready_o low during the stall, sample_o held stable, no loss or duplication, output order preserved.
- Async reset asserted with 2 beats in flight -> sample_valid_o and gain_o go to 0 immediately. After release, the first new beat emerges 2 cycles after acceptance.
